// File: rtl/comparator_mon_nb.sv
// Registered threshold comparator with debounced above/below status, crossing pulses and counter.
// Optional hysteresis band on the crossing qualifiers when COMPARATOR_HYST_EN is defined.
module comparator_mon_nb #(
    parameter int unsigned N        = 32,
    parameter bit          SIGNED   = 1'b0,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
`ifdef COMPARATOR_HYST_EN
    input  logic [N-1:0] HYST,
`endif
    output logic         out_valid,
    output logic         EQ,
    output logic         LT,
    output logic         GT,
    output logic         above,
    output logic         rise,
    output logic         fall,
    output logic [15:0]  cross_count
);

    localparam logic [0:0] ST_BELOW   = 1'b0;
    localparam logic [0:0] ST_ABOVE   = 1'b1;
    localparam logic [8:0] DEB_TARGET = 9'(DEBOUNCE);

    logic [N:0]   a_ext, b_ext;
    logic         eq_c, lt_c, gt_c, up_c, dn_c;
    logic [0:0]   state_q, state_d;
    logic [7:0]   cnt_q, cnt_d;
    logic [8:0]   cnt_inc;
    logic         valid_d, eq_d, lt_d, gt_d, rise_d, fall_d;
    logic [15:0]  cross_d, cross_inc;

    assign a_ext = {SIGNED & A[N-1], A};
    assign b_ext = {SIGNED & B[N-1], B};
    assign eq_c  = (a_ext == b_ext);
    assign lt_c  = ($signed(a_ext) < $signed(b_ext));
    assign gt_c  = ($signed(a_ext) > $signed(b_ext));

`ifdef COMPARATOR_HYST_EN
    // N+2 bits holds B +/- HYST without wrap, so out-of-range limits simply never qualify.
    logic [N+1:0] a_h, b_h, hi_lim, lo_lim;
    assign a_h    = {{2{SIGNED & A[N-1]}}, A};
    assign b_h    = {{2{SIGNED & B[N-1]}}, B};
    assign hi_lim = b_h + {2'b00, HYST};
    assign lo_lim = b_h - {2'b00, HYST};
    assign up_c   = ($signed(a_h) > $signed(hi_lim));
    assign dn_c   = ($signed(a_h) < $signed(lo_lim));
`else
    assign up_c   = gt_c;
    assign dn_c   = ~gt_c;
`endif

    assign cnt_inc   = {1'b0, cnt_q} + 9'd1;
    assign cross_inc = (cross_count == 16'hFFFF) ? cross_count : cross_count + 16'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cross_d = cross_count;
        valid_d = in_valid;
        eq_d    = EQ;
        lt_d    = LT;
        gt_d    = GT;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (in_valid) begin
            eq_d = eq_c;
            lt_d = lt_c;
            gt_d = gt_c;
            case (state_q)
                ST_BELOW: begin
                    if (!up_c) begin
                        cnt_d = '0;
                    end else if (cnt_inc == DEB_TARGET) begin
                        state_d = ST_ABOVE;
                        cnt_d   = '0;
                        rise_d  = 1'b1;
                        cross_d = cross_inc;
                    end else begin
                        cnt_d = cnt_inc[7:0];
                    end
                end
                default: begin
                    if (!dn_c) begin
                        cnt_d = '0;
                    end else if (cnt_inc == DEB_TARGET) begin
                        state_d = ST_BELOW;
                        cnt_d   = '0;
                        fall_d  = 1'b1;
                        cross_d = cross_inc;
                    end else begin
                        cnt_d = cnt_inc[7:0];
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_BELOW;
            cnt_q       <= '0;
            out_valid   <= 1'b0;
            EQ          <= 1'b0;
            LT          <= 1'b0;
            GT          <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            cross_count <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid   <= valid_d;
            EQ          <= eq_d;
            LT          <= lt_d;
            GT          <= gt_d;
            rise        <= rise_d;
            fall        <= fall_d;
            cross_count <= cross_d;
        end
    end

    assign above = state_q;

endmodule

// File: tb/tb_comparator_mon_nb.sv
// Directed bench for comparator_mon_nb: unsigned/DEBOUNCE=4, signed and DEBOUNCE=1 instances share stimulus.
module tb_comparator_mon_nb;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] a = '0, b = '0;
`ifdef COMPARATOR_HYST_EN
    logic [31:0] hyst = '0;
`endif
    int total = 0;
    int bad = 0;

    logic ov0, eq0, lt0, gt0, ab0, ri0, fa0;
    logic [15:0] cc0;
    logic ov1, eq1, lt1, gt1, ab1, ri1, fa1;
    logic [15:0] cc1;
    logic ov2, eq2, lt2, gt2, ab2, ri2, fa2;
    logic [15:0] cc2;

    // Packed views: {out_valid, EQ, LT, GT, above, rise, fall}
    logic [6:0] st0, st1, st2;
    assign st0 = {ov0, eq0, lt0, gt0, ab0, ri0, fa0};
    assign st1 = {ov1, eq1, lt1, gt1, ab1, ri1, fa1};
    assign st2 = {ov2, eq2, lt2, gt2, ab2, ri2, fa2};

    always #5 clk = ~clk;

    comparator_mon_nb #(.N(32), .SIGNED(1'b0), .DEBOUNCE(4)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(a), .B(b),
`ifdef COMPARATOR_HYST_EN
        .HYST(hyst),
`endif
        .out_valid(ov0), .EQ(eq0), .LT(lt0), .GT(gt0), .above(ab0), .rise(ri0), .fall(fa0),
        .cross_count(cc0)
    );

    comparator_mon_nb #(.N(32), .SIGNED(1'b1), .DEBOUNCE(4)) u_sgn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(a), .B(b),
`ifdef COMPARATOR_HYST_EN
        .HYST(hyst),
`endif
        .out_valid(ov1), .EQ(eq1), .LT(lt1), .GT(gt1), .above(ab1), .rise(ri1), .fall(fa1),
        .cross_count(cc1)
    );

    comparator_mon_nb #(.N(32), .SIGNED(1'b0), .DEBOUNCE(1)) u_deb1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .A(a), .B(b),
`ifdef COMPARATOR_HYST_EN
        .HYST(hyst),
`endif
        .out_valid(ov2), .EQ(eq2), .LT(lt2), .GT(gt2), .above(ab2), .rise(ri2), .fall(fa2),
        .cross_count(cc2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic sample(input logic [31:0] av, input logic [31:0] bv);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        a = 32'd9;
        b = 32'd1;
        in_valid = 1'b1;
        tick();
        do_reset();
        total++;
        if (st0 !== 7'b0 || cc0 !== 16'd0) begin
            bad++;
            $display("FAIL reset_state got st=%b cc=%0d want st=0000000 cc=0", st0, cc0);
        end
    endtask

    task automatic test_compare();
        sample(32'd5, 32'd5);
        total++;
        if (st0[6:3] !== 4'b1100) begin
            bad++;
            $display("FAIL cmp_eq got %b want 1100", st0[6:3]);
        end
        sample(32'd3, 32'd5);
        total++;
        if (st0[6:3] !== 4'b1010) begin
            bad++;
            $display("FAIL cmp_lt got %b want 1010", st0[6:3]);
        end
        sample(32'd7, 32'd5);
        total++;
        if (st0[6:3] !== 4'b1001) begin
            bad++;
            $display("FAIL cmp_gt got %b want 1001", st0[6:3]);
        end
        gap();
        total++;
        if (st0[6:3] !== 4'b0001) begin
            bad++;
            $display("FAIL cmp_hold got %b want 0001", st0[6:3]);
        end
    endtask

    task automatic test_signed();
        sample(32'hFFFF_FFFF, 32'd1);
        total++;
        if (st1[6:3] !== 4'b1010) begin
            bad++;
            $display("FAIL signed_lt got %b want 1010", st1[6:3]);
        end
        total++;
        if (st0[6:3] !== 4'b1001) begin
            bad++;
            $display("FAIL unsigned_gt got %b want 1001", st0[6:3]);
        end
    endtask

    task automatic test_debounce();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            sample(32'd101, 32'd100);
            if (i == 0) gap();
            total++;
            if (ab0 !== 1'b0 || ri0 !== 1'b0) begin
                bad++;
                $display("FAIL deb_pre%0d got above=%b rise=%b want 0 0", i, ab0, ri0);
            end
        end
        sample(32'd99, 32'd100);
        for (int i = 0; i < 4; i++) begin
            sample(32'd101, 32'd100);
            if (i < 3) begin
                total++;
                if (ab0 !== 1'b0 || ri0 !== 1'b0) begin
                    bad++;
                    $display("FAIL deb_run%0d got above=%b rise=%b want 0 0", i, ab0, ri0);
                end
            end
            if (i == 1) gap();
        end
        total++;
        if (st0 !== 7'b1001110 || cc0 !== 16'd1) begin
            bad++;
            $display("FAIL deb_rise got st=%b cc=%0d want st=1001110 cc=1", st0, cc0);
        end
        gap();
        total++;
        if (ri0 !== 1'b0 || ab0 !== 1'b1) begin
            bad++;
            $display("FAIL deb_rise_pulse got rise=%b above=%b want 0 1", ri0, ab0);
        end
    endtask

    task automatic test_fall();
        logic [31:0] dn_val;
`ifdef COMPARATOR_HYST_EN
        hyst = '0;
        dn_val = 32'd99;
`else
        dn_val = 32'd100;
`endif
        for (int i = 0; i < 3; i++) begin
            sample(dn_val, 32'd100);
            total++;
            if (ab0 !== 1'b1 || fa0 !== 1'b0) begin
                bad++;
                $display("FAIL fall_pre%0d got above=%b fall=%b want 1 0", i, ab0, fa0);
            end
        end
        sample(dn_val, 32'd100);
        total++;
        if (ab0 !== 1'b0 || fa0 !== 1'b1 || ri0 !== 1'b0 || cc0 !== 16'd2) begin
            bad++;
            $display("FAIL fall_edge got above=%b fall=%b rise=%b cc=%0d want 0 1 0 2",
                     ab0, fa0, ri0, cc0);
        end
        sample(dn_val, 32'd100);
        total++;
        if (fa0 !== 1'b0) begin
            bad++;
            $display("FAIL fall_pulse got %b want 0", fa0);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dn_val;
`ifdef COMPARATOR_HYST_EN
        dn_val = 32'd99;
`else
        dn_val = 32'd100;
`endif
        for (int i = 0; i < 4; i++) sample(32'd101, 32'd100);
        total++;
        if (ab0 !== 1'b1 || cc0 !== 16'd3) begin
            bad++;
            $display("FAIL mid_setup got above=%b cc=%0d want 1 3", ab0, cc0);
        end
        sample(dn_val, 32'd100);
        reset = 1'b1;
        sample(dn_val, 32'd100);
        reset = 1'b0;
        total++;
        if (st0 !== 7'b0 || cc0 !== 16'd0) begin
            bad++;
            $display("FAIL mid_reset got st=%b cc=%0d want 0000000 0", st0, cc0);
        end
        for (int i = 0; i < 3; i++) begin
            sample(32'd101, 32'd100);
            total++;
            if (ri0 !== 1'b0 || ab0 !== 1'b0) begin
                bad++;
                $display("FAIL mid_restart%0d got rise=%b above=%b want 0 0", i, ri0, ab0);
            end
        end
        sample(32'd101, 32'd100);
        total++;
        if (ri0 !== 1'b1 || cc0 !== 16'd1) begin
            bad++;
            $display("FAIL mid_rise got rise=%b cc=%0d want 1 1", ri0, cc0);
        end
    endtask

    task automatic test_saturate();
        int exp_cc;
        do_reset();
        for (int i = 0; i < 65540; i++) begin
            sample((i % 2 == 0) ? 32'd101 : 32'd99, 32'd100);
            if (i >= 65532) begin
                exp_cc = (i + 1 > 65535) ? 65535 : i + 1;
                total++;
                if (ri2 !== (i % 2 == 0) || fa2 !== (i % 2 == 1) || cc2 !== 16'(exp_cc)) begin
                    bad++;
                    $display("FAIL sat_%0d got rise=%b fall=%b cc=%0d want %0d %0d %0d",
                             i, ri2, fa2, cc2, (i % 2 == 0), (i % 2 == 1), exp_cc);
                end
            end
        end
    endtask

`ifdef COMPARATOR_HYST_EN
    task automatic test_hyst();
        logic [31:0] probes [4];
        probes = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 32'h0, 32'h7FFF_FFFF};
        do_reset();
        hyst = 32'd10;
        sample(32'd105, 32'd100);
        total++;
        if (ri2 !== 1'b0 || ab2 !== 1'b0) begin
            bad++;
            $display("FAIL hyst_in_band_up got rise=%b above=%b want 0 0", ri2, ab2);
        end
        sample(32'd111, 32'd100);
        total++;
        if (ri2 !== 1'b1 || ab2 !== 1'b1) begin
            bad++;
            $display("FAIL hyst_rise got rise=%b above=%b want 1 1", ri2, ab2);
        end
        sample(32'd95, 32'd100);
        total++;
        if (fa2 !== 1'b0 || ab2 !== 1'b1) begin
            bad++;
            $display("FAIL hyst_in_band_dn got fall=%b above=%b want 0 1", fa2, ab2);
        end
        sample(32'd89, 32'd100);
        total++;
        if (fa2 !== 1'b1 || ab2 !== 1'b0) begin
            bad++;
            $display("FAIL hyst_fall got fall=%b above=%b want 1 0", fa2, ab2);
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            sample(probes[i], 32'hFFFF_FFF8);
            total++;
            if (ri2 !== 1'b0 || ab2 !== 1'b0) begin
                bad++;
                $display("FAIL hyst_top%0d got rise=%b above=%b want 0 0", i, ri2, ab2);
            end
        end
        hyst = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_compare();
        test_signed();
        test_debounce();
        test_fall();
        test_reset_mid();
`ifdef COMPARATOR_HYST_EN
        test_hyst();
`endif
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/comparator_mon_nb.md
Name: comparator_mon_nb

Overview:
- Registered, parametrised successor to the combinational n-bit comparator.
- Compares a sample stream A against a threshold B and outputs registered EQ/LT/GT flags.
- Adds a debounced above/below status, one-cycle crossing pulses and a saturating crossing counter.
- Sits on the solver datapath to monitor state variables (step index, error estimate) against limits set by the controller.

Parameters:
- N, 32, operand width of A and B.
- SIGNED, 0, 1 = two's-complement compare; 0 = unsigned compare.
- DEBOUNCE, 4, consecutive qualifying samples needed to change status; legal range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  A and B are sampled on this cycle.
- A  in  N  sample value.
- B  in  N  threshold value.
- out_valid  out  1  EQ/LT/GT hold the result of the previous valid sample.
- EQ  out  1  registered A == B.
- LT  out  1  registered A < B.
- GT  out  1  registered A > B.
- above  out  1  debounced status: 1 = above threshold.
- rise  out  1  one-cycle pulse on a below-to-above transition.
- fall  out  1  one-cycle pulse on an above-to-below transition.
- cross_count  out  16  number of transitions, saturating.

Behaviour:
- Reset (synchronous, active-high) clears every output to 0, sets the FSM to BELOW and clears the debounce counter. Reset asserted mid-debounce discards the partial count.
- Compare latency is 1 cycle. On a clk edge with in_valid=1:
  - EQ/LT/GT are loaded with the compare of A and B; exactly one of the three is 1.
  - out_valid is set to 1.
- On a clk edge with in_valid=0:
  - out_valid goes to 0.
  - EQ/LT/GT, above, the counter and the FSM state are held.
  - rise and fall go to 0.
- Compare arithmetic:
  - SIGNED=1: operands are sign-extended to N+1 bits.
  - SIGNED=0: operands are zero-extended to N+1 bits.
  - No overflow is possible.
- Qualifiers, evaluated on the current valid sample:
  - up_cond = A > B.
  - dn_cond = !(A > B), i.e. EQ or LT.
  - Hysteresis modifies both qualifiers; see Optional Feature.
- FSM states: BELOW (above=0), ABOVE (above=1). cnt is an 8-bit counter.
- BELOW, valid sample:
  - up_cond=1 and cnt+1==DEBOUNCE: go to ABOVE, cnt=0, rise=1 for one cycle, cross_count+1.
  - up_cond=1 otherwise: cnt+1.
  - up_cond=0: cnt=0.
- ABOVE: mirror of BELOW using dn_cond; the transition asserts fall instead of rise.
- DEBOUNCE=1: status changes on the same edge as the first qualifying sample.
- Non-consecutive qualifying samples: any valid non-qualifying sample resets cnt. Invalid cycles do not reset cnt and do not advance it.
- above updates on the same edge as EQ/LT/GT, so the status change is visible 1 cycle after the qualifying sample.
- rise and fall are never both 1 in the same cycle.
- cross_count saturates at 16'hFFFF and does not wrap.

Optional Feature:
- Macro: COMPARATOR_HYST_EN.
- Defined:
  - Adds input port HYST, N bits, unsigned.
  - up_cond = A > B + HYST; dn_cond = A < B - HYST.
  - Both are computed in N+2 bits with B sign- or zero-extended per SIGNED.
  - If B + HYST exceeds the representable maximum of A, up_cond is never true.
  - If B - HYST falls below the representable minimum of A, dn_cond is never true.
  - Samples inside the band reset cnt.
  - EQ/LT/GT are unaffected.
- Undefined: no HYST port; qualifiers are exactly as in Behaviour.

Test Plan:
- Reset, then N=32, SIGNED=0: A=5, B=5 valid → next cycle out_valid=1, EQ=1, LT=0, GT=0. A=3, B=5 → LT=1. A=7, B=5 → GT=1.
- SIGNED=1: A=32'hFFFFFFFF (-1), B=1 → LT=1. With SIGNED=0, same operands → GT=1.
- DEBOUNCE=4, B=100: A=101 ×3, A=99 ×1, A=101 ×4, all valid → no rise until after the 4th consecutive 101; then rise=1 for one cycle, above=1, cross_count=1. in_valid=0 gaps inserted inside the run do not break the count.
- From ABOVE, B=100: A=100 ×4 (EQ counts as down) → fall pulse, above=0, cross_count=2. Assert reset on the 2nd down sample of a repeated run → all outputs 0, no fall pulse, cnt restarts.
- Force 65540 alternating crossings with DEBOUNCE=1 → cross_count stops at 16'hFFFF and rise/fall keep pulsing.
- COMPARATOR_HYST_EN, B=100, HYST=10: A=105 → no rise; A=111 → rise. A=95 → no fall; A=89 → fall. Repeat with B=32'hFFFFFFF8 unsigned, HYST=10 → rise is never asserted for any A.
